pmod_da2_serializer: RTL and testbench



---
 rtl/pmod_da2_serializer.sv | 150 +++++++++++++++
 tb/tb_pmod_da2_serializer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pmod_da2_serializer.sv
// Dual-channel PMOD DA2 (2x DAC121S101) serializer: two signed 16-bit samples -> one shared SPI frame.
// Optional macro DA2_ROUND_EN: round-to-nearest before conversion, adds one clock of latency.
module pmod_da2_serializer #(
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned SYNC_HOLD = 2,
  parameter logic [1:0]  PD_MODE   = 2'b00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] din_a,
  input  logic [15:0] din_b,
  output logic        sclk,
  output logic        sync_n,
  output logic        sdata_a,
  output logic        sdata_b,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FALL_W = 5;
  localparam int unsigned WORD_W = 16;
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(SYNC_HOLD - 1);
  localparam logic [FALL_W-1:0] FALLS    = FALL_W'(WORD_W);

  typedef enum logic [2:0] {IDLE, ROUND, LOAD, SHIFT, GAP} state_t;

  state_t              state;
  logic [WORD_W-1:0]   shift_a, shift_b;
  logic [CNT_W-1:0]    div_cnt, gap_cnt;
  logic [FALL_W-1:0]   fall_cnt;
  logic [11:0]         code_a, code_b;
  logic                unused_bits;

`ifdef DA2_ROUND_EN
  logic [15:0] cap_a, cap_b;
  logic [15:0] sum_a, sum_b;

  // 16-bit add cannot wrap except for din >= 0x7FF8, which saturates instead
  assign sum_a  = cap_a + 16'd8;
  assign sum_b  = cap_b + 16'd8;
  assign code_a = (cap_a[15:3] == 13'h0FFF) ? 12'hFFF : {~sum_a[15], sum_a[14:4]};
  assign code_b = (cap_b[15:3] == 13'h0FFF) ? 12'hFFF : {~sum_b[15], sum_b[14:4]};
  assign unused_bits = ^{sum_a[3:0], sum_b[3:0]};
`else
  assign code_a = {~din_a[15], din_a[14:4]};
  assign code_b = {~din_b[15], din_b[14:4]};
  assign unused_bits = ^{din_a[3:0], din_b[3:0]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sclk     <= 1'b1;
      sync_n   <= 1'b1;
      sdata_a  <= 1'b0;
      sdata_b  <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      shift_a  <= '0;
      shift_b  <= '0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
      fall_cnt <= '0;
`ifdef DA2_ROUND_EN
      cap_a    <= '0;
      cap_b    <= '0;
`endif
    end else begin
      // Any strobe outside IDLE is lost; the frame in flight continues untouched
      if (en && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (en) begin
`ifdef DA2_ROUND_EN
            cap_a <= din_a;
            cap_b <= din_b;
            state <= ROUND;
`else
            shift_a <= {2'b00, PD_MODE, code_a};
            shift_b <= {2'b00, PD_MODE, code_b};
            state   <= LOAD;
`endif
          end
        end

`ifdef DA2_ROUND_EN
        ROUND: begin
          busy    <= 1'b1;
          shift_a <= {2'b00, PD_MODE, code_a};
          shift_b <= {2'b00, PD_MODE, code_b};
          state   <= LOAD;
        end
`endif

        LOAD: begin
          busy     <= 1'b1;
          sync_n   <= 1'b0;
          sclk     <= 1'b1;
          sdata_a  <= shift_a[WORD_W-1];
          sdata_b  <= shift_b[WORD_W-1];
          shift_a  <= {shift_a[WORD_W-2:0], 1'b0};
          shift_b  <= {shift_b[WORD_W-2:0], 1'b0};
          div_cnt  <= '0;
          fall_cnt <= '0;
          state    <= SHIFT;
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (sclk) begin
              sclk     <= 1'b0;
              fall_cnt <= fall_cnt + 5'd1;
            end else if (fall_cnt == FALLS) begin
              sclk    <= 1'b1;
              sync_n  <= 1'b1;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              // Data moves only on SCLK rising edges; the DAC samples on falls
              sclk    <= 1'b1;
              sdata_a <= shift_a[WORD_W-1];
              sdata_b <= shift_b[WORD_W-1];
              shift_a <= {shift_a[WORD_W-2:0], 1'b0};
              shift_b <= {shift_b[WORD_W-2:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 4'd1;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_da2_serializer.sv
// Directed bench for pmod_da2_serializer: two instances (CLK_DIV=1 and CLK_DIV=3) on one clock.
// Handles both builds of DA2_ROUND_EN via latency and rounding-dependent expectations.
module tb_pmod_da2_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en1, en3;
  logic [15:0] a1, b1, a3, b3;
  logic        sclk1, sync1, sda1, sdb1, busy1, ovr1;
  logic        sclk3, sync3, sda3, sdb3, busy3, ovr3;
  int          total = 0;
  int          bad   = 0;

`ifdef DA2_ROUND_EN
  localparam int          LAT     = 1;
  localparam logic [11:0] EXP_RND = 12'h924;
`else
  localparam int          LAT     = 0;
  localparam logic [11:0] EXP_RND = 12'h923;
`endif

  always #5 clk = ~clk;

  pmod_da2_serializer #(.CLK_DIV(1), .SYNC_HOLD(2), .PD_MODE(2'b00)) u_div1 (
    .clk(clk), .reset(reset), .en(en1), .din_a(a1), .din_b(b1),
    .sclk(sclk1), .sync_n(sync1), .sdata_a(sda1), .sdata_b(sdb1),
    .busy(busy1), .overrun(ovr1)
  );

  pmod_da2_serializer #(.CLK_DIV(3), .SYNC_HOLD(2), .PD_MODE(2'b00)) u_div3 (
    .clk(clk), .reset(reset), .en(en3), .din_a(a3), .din_b(b3),
    .sclk(sclk3), .sync_n(sync3), .sdata_a(sda3), .sdata_b(sdb3),
    .busy(busy3), .overrun(ovr3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe one frame, then track it edge by edge: cycle c is the state just after edge c (edge 0 samples en)
  task automatic run_frame(input bit sel, input logic [15:0] a, input logic [15:0] b,
                           input int drop1, input int drop2, input int abort_at,
                           output logic [15:0] cap_a, output logic [15:0] cap_b,
                           output int falls, output int t_fall, output int t_rise,
                           output int t_done);
    logic s_sclk, s_sync, s_busy, s_da, s_db, prev;
    cap_a = '0; cap_b = '0; falls = 0;
    t_fall = -1; t_rise = -1; t_done = -1;
    @(negedge clk);
    if (sel) begin en3 = 1'b1; a3 = a; b3 = b; end
    else     begin en1 = 1'b1; a1 = a; b1 = b; end
    prev = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      en1 = !sel && ((c + 1 == drop1) || (c + 1 == drop2));
      en3 =  sel && ((c + 1 == drop1) || (c + 1 == drop2));
      s_sclk = sel ? sclk3 : sclk1;
      s_sync = sel ? sync3 : sync1;
      s_busy = sel ? busy3 : busy1;
      s_da   = sel ? sda3  : sda1;
      s_db   = sel ? sdb3  : sdb1;
      if (!s_sync && t_fall < 0) t_fall = c;
      if (prev && !s_sclk && !s_sync) begin
        cap_a = {cap_a[14:0], s_da};
        cap_b = {cap_b[14:0], s_db};
        falls++;
        if (falls == abort_at) begin
          reset = 1'b1;
          return;
        end
      end
      if (t_fall >= 0 && s_sync && t_rise < 0) t_rise = c;
      if (t_fall >= 0 && !s_busy) begin
        t_done = c;
        break;
      end
      prev = s_sclk;
    end
  endtask

  initial begin
    logic [15:0] ca, cb;
    int          nf, tf, tr, td, toggles;
    logic        last;

    reset = 1'b1; en1 = 1'b0; en3 = 1'b0;
    a1 = '0; b1 = '0; a3 = '0; b3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Idle after reset: no SCLK activity, all flags low
    toggles = 0; last = sclk1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sclk1 !== last || sclk3 !== 1'b1) toggles++;
      last = sclk1;
    end
    check("idle_toggles", 32'(toggles), 32'd0);
    check("idle_sclk",    32'(sclk1),   32'd1);
    check("idle_sync",    32'(sync1),   32'd1);
    check("idle_busy",    32'(busy1),   32'd0);
    check("idle_ovr",     32'(ovr1),    32'd0);
    check("idle_sda",     32'(sda1),    32'd0);

    // CLK_DIV=1: mid-scale and positive full-scale
    run_frame(1'b0, 16'h0000, 16'h7FFF, 0, 0, 0, ca, cb, nf, tf, tr, td);
    check("d1_falls", 32'(nf), 32'd16);
    check("d1_a",     32'(ca), 32'h0800);
    check("d1_b",     32'(cb), 32'h0FFF);
    check("d1_tfall", 32'(tf), 32'(1 + LAT));
    check("d1_trise", 32'(tr), 32'(33 + LAT));
    check("d1_tdone", 32'(td), 32'(35 + LAT));
    check("d1_sclk_end", 32'(sclk1), 32'd1);

    // CLK_DIV=3: negative full-scale and a mid value
    run_frame(1'b1, 16'h8000, 16'h1230, 0, 0, 0, ca, cb, nf, tf, tr, td);
    check("d3_falls", 32'(nf), 32'd16);
    check("d3_a",     32'(ca), 32'h0000);
    check("d3_b",     32'(cb), 32'h0923);
    check("d3_tfall", 32'(tf), 32'(1 + LAT));
    check("d3_trise", 32'(tr), 32'(97 + LAT));
    check("d3_tdone", 32'(td), 32'(99 + LAT));

    // Strobes at +10 and in the last GAP cycle are dropped; rounding-sensitive data
    check("ovr_pre", 32'(ovr1), 32'd0);
    run_frame(1'b0, 16'h1238, 16'h7FFC, 10, 35 + LAT, 0, ca, cb, nf, tf, tr, td);
    check("ov_falls", 32'(nf), 32'd16);
    check("ov_a",     32'(ca), 32'(EXP_RND));
    check("ov_b",     32'(cb), 32'h0FFF);
    check("ov_tdone", 32'(td), 32'(35 + LAT));
    check("ov_flag",  32'(ovr1), 32'd1);
    check("ov_other", 32'(ovr3), 32'd0);

    // Strobe one cycle after the dropped one is accepted at once
    run_frame(1'b0, 16'h4000, 16'hFFF0, 0, 0, 0, ca, cb, nf, tf, tr, td);
    check("nx_tfall", 32'(tf), 32'(1 + LAT));
    check("nx_a",     32'(ca), 32'h0C00);
    check("nx_b",     32'(cb), 32'h07FF);
    check("nx_ovr",   32'(ovr1), 32'd1);

    // Reset at fall 7 aborts the frame on the next edge
    run_frame(1'b0, 16'h1234, 16'h5678, 0, 0, 7, ca, cb, nf, tf, tr, td);
    check("rst_falls", 32'(nf), 32'd7);
    @(posedge clk); #1;
    check("rst_sync", 32'(sync1), 32'd1);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_sclk", 32'(sclk1), 32'd1);
    check("rst_ovr",  32'(ovr1),  32'd0);
    reset = 1'b0;

    run_frame(1'b0, 16'h8000, 16'h1230, 0, 0, 0, ca, cb, nf, tf, tr, td);
    check("post_falls", 32'(nf), 32'd16);
    check("post_a",     32'(ca), 32'h0000);
    check("post_b",     32'(cb), 32'h0923);
    check("post_trise", 32'(tr), 32'(33 + LAT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
